// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory stage with an internal byte-lane data memory.
// Stores commit on the accept edge. Loads read the memory on the accept edge,
// then deliver the extracted lane LAT cycles later. busy stalls upstream only
// while a multi-cycle load is waiting for its result slot.
module mem_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2048,
    parameter int LAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_store_data,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic            in_reg_dest,
    input  logic            fwd_en,
    input  logic [XLEN-1:0] fwd_data,
    output logic            busy,
    output logic            wb_valid,
    output logic [31:0]     wb_ir,
    output logic [XLEN-1:0] wb_alu,
    output logic [XLEN-1:0] wb_load_data,
    output logic            wb_is_load,
    output logic            wb_reg_dest,
    output logic            wb_misalign
);

    localparam int NB = XLEN / 8;
    localparam int B  = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Number of cycles spent in WAIT before the result slot; zero when LAT=1.
    localparam logic [2:0] WAIT_CNT = 3'(LAT - 1);

    // True when the access does not start on a multiple of its own size.
    // A doubleword does not exist on a 32-bit datapath, so it always traps.
    function automatic logic misaligned_f(input logic [1:0] size, input logic [B-1:0] off);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = off[0];
            2'b10:   m = |off[1:0];
            default: m = (XLEN == 32) ? 1'b1 : |off;
        endcase
        return m;
    endfunction

    // One bit per byte lane touched by an access of the given size and offset.
    function automatic logic [NB-1:0] lane_mask_f(input logic [1:0] size, input logic [B-1:0] off);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << size));
        end
        return m << off;
    endfunction

    // Expand a byte-lane mask into a bit mask across the full word.
    function automatic logic [XLEN-1:0] bit_mask_f(input logic [NB-1:0] lanes);
        logic [XLEN-1:0] bm;
        for (int i = 0; i < NB; i++) begin
            bm[8*i +: 8] = {8{lanes[i]}};
        end
        return bm;
    endfunction

    // Pull the addressed lane down to bit 0, then sign- or zero-extend it.
    // keep covers the lane width; keep ^ (keep >> 1) isolates its top bit.
    function automatic logic [XLEN-1:0] load_extract_f(
        input logic [XLEN-1:0] word,
        input logic [B-1:0]    off,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] keep;
        logic            sign;
        int              nbits;
        sh    = word >> {off, 3'b000};
        nbits = 8 << size;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        keep = {XLEN{1'b1}} >> (XLEN - nbits);
        sh   = sh & keep;
        sign = |(sh & (keep ^ (keep >> 1)));
        if (!uns && sign) begin
            sh = sh | ~keep;
        end
        return sh;
    endfunction

    logic [XLEN-1:0] mem [DEPTH];

    logic [0:0]      state_p0;
    logic [2:0]      cnt_p0;
    logic [XLEN-1:0] ld_data_p0;
    logic [31:0]     ir_p0;
    logic [XLEN-1:0] alu_p0;
    logic            rd_p0;

    logic            accept;
    logic            op_store;
    logic            op_load;
    logic            op_mem;
    logic            mis;
    logic [B-1:0]    off;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] eff_data;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] wr_bits;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] ld_ext;
    logic            ld_multi;

    // A load that also claims to be a store is treated purely as a store.
    assign busy     = (state_p0 == ST_WAIT);
    assign accept   = in_valid && !busy;
    assign op_store = in_is_store;
    assign op_load  = in_is_load && !in_is_store;
    assign op_mem   = op_store || op_load;
    assign off      = in_addr[B-1:0];
    assign idx      = in_addr[AW+B-1:B];
    assign mis      = op_mem && misaligned_f(in_size, off);
    assign eff_data = fwd_en ? fwd_data : in_store_data;
    assign wr_data  = eff_data << {off, 3'b000};
    assign wr_bits  = bit_mask_f(lane_mask_f(in_size, off));
    assign rd_word  = mem[idx];
    assign ld_ext   = load_extract_f(rd_word, off, in_size, in_unsigned);
    assign ld_multi = op_load && !mis && (LAT > 1);

    // ---- accept edge: memory commit ----
    // Commit aligned stores into the addressed byte lanes; the reset edge never writes.
    always_ff @(posedge clk) begin
        if (!reset && accept && op_store && !mis) begin
            mem[idx] <= (mem[idx] & ~wr_bits) | (wr_data & wr_bits);
        end
    end

    // Capture a multi-cycle load's result and tags until its slot comes up.
    always_ff @(posedge clk) begin
        if (accept && ld_multi) begin
            ld_data_p0 <= ld_ext;
            ir_p0      <= in_ir;
            alu_p0     <= in_addr;
            rd_p0      <= in_reg_dest;
        end
    end

    // ---- writeback boundary: load FSM and result registers ----
    // Sequence loads through WAIT and publish every completed op for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0     <= ST_IDLE;
            cnt_p0       <= 3'd0;
            wb_valid     <= 1'b0;
            wb_ir        <= 32'd0;
            wb_alu       <= '0;
            wb_load_data <= '0;
            wb_is_load   <= 1'b0;
            wb_reg_dest  <= 1'b0;
            wb_misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_p0)
                ST_IDLE: begin
                    if (accept) begin
                        if (ld_multi) begin
                            state_p0 <= ST_WAIT;
                            cnt_p0   <= WAIT_CNT;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_ir        <= in_ir;
                            wb_alu       <= in_addr;
                            wb_is_load   <= op_load;
                            wb_reg_dest  <= in_reg_dest;
                            wb_misalign  <= mis;
                            wb_load_data <= (op_load && !mis) ? ld_ext : '0;
                        end
                    end
                end
                default: begin
                    // The last WAIT cycle hands the result over and reopens accept.
                    if (cnt_p0 == 3'd1) begin
                        state_p0     <= ST_IDLE;
                        cnt_p0       <= 3'd0;
                        wb_valid     <= 1'b1;
                        wb_ir        <= ir_p0;
                        wb_alu       <= alu_p0;
                        wb_is_load   <= 1'b1;
                        wb_reg_dest  <= rd_p0;
                        wb_misalign  <= 1'b0;
                        wb_load_data <= ld_data_p0;
                    end else begin
                        cnt_p0 <= cnt_p0 - 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: three instances (LAT = 1, 3, 4) checked against
// a byte-addressed reference memory and directed scenarios.
module tb_mem_stage_pipe;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] fdata;
        logic        ld;
        logic        st;
        logic        uns;
        logic        rd;
        logic        fwd;
        logic [1:0]  size;
    } op_t;

    typedef struct {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] data;
        logic        is_load;
        logic        rd;
        logic        mis;
    } wb_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid_a      [3];
    logic [31:0] in_ir_a         [3];
    logic [31:0] in_addr_a       [3];
    logic [31:0] in_store_data_a [3];
    logic        in_is_load_a    [3];
    logic        in_is_store_a   [3];
    logic [1:0]  in_size_a       [3];
    logic        in_unsigned_a   [3];
    logic        in_reg_dest_a   [3];
    logic        fwd_en_a        [3];
    logic [31:0] fwd_data_a      [3];
    logic        busy_a          [3];
    logic        wb_valid_a      [3];
    logic [31:0] wb_ir_a         [3];
    logic [31:0] wb_alu_a        [3];
    logic [31:0] wb_load_data_a  [3];
    logic        wb_is_load_a    [3];
    logic        wb_reg_dest_a   [3];
    logic        wb_misalign_a   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_pipe #(
            .XLEN (32),
            .DEPTH(2048),
            .LAT  ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid_a[g]),
            .in_ir        (in_ir_a[g]),
            .in_addr      (in_addr_a[g]),
            .in_store_data(in_store_data_a[g]),
            .in_is_load   (in_is_load_a[g]),
            .in_is_store  (in_is_store_a[g]),
            .in_size      (in_size_a[g]),
            .in_unsigned  (in_unsigned_a[g]),
            .in_reg_dest  (in_reg_dest_a[g]),
            .fwd_en       (fwd_en_a[g]),
            .fwd_data     (fwd_data_a[g]),
            .busy         (busy_a[g]),
            .wb_valid     (wb_valid_a[g]),
            .wb_ir        (wb_ir_a[g]),
            .wb_alu       (wb_alu_a[g]),
            .wb_load_data (wb_load_data_a[g]),
            .wb_is_load   (wb_is_load_a[g]),
            .wb_reg_dest  (wb_reg_dest_a[g]),
            .wb_misalign  (wb_misalign_a[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference memory: plain bytes, little-endian, 2048 words * 4 bytes.
    logic [7:0] rmem [3][8192];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr[0];
            2'd2:    return addr[1:0] != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_store(input int k, input logic [31:0] addr, input logic [1:0] size,
                                        input logic [31:0] data);
        int n;
        int base;
        n    = 1 << size;
        base = int'(addr & 32'd8191);
        for (int i = 0; i < n; i++) rmem[k][base + i] = data[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        logic [63:0] v;
        int n;
        int base;
        n    = 1 << size;
        base = int'(addr & 32'd8191);
        v    = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(rmem[k][base + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic op_t mk_ld(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        op_t o;
        o.ir = $urandom(); o.addr = addr; o.sdata = $urandom(); o.fdata = $urandom();
        o.ld = 1'b1; o.st = 1'b0; o.uns = uns; o.rd = 1'b1; o.fwd = 1'b0; o.size = size;
        return o;
    endfunction

    function automatic op_t mk_st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        op_t o;
        o.ir = $urandom(); o.addr = addr; o.sdata = data; o.fdata = $urandom();
        o.ld = 1'b0; o.st = 1'b1; o.uns = 1'b0; o.rd = 1'b0; o.fwd = 1'b0; o.size = size;
        return o;
    endfunction

    task automatic drive(input int k, input op_t o);
        in_ir_a[k] = o.ir; in_addr_a[k] = o.addr; in_store_data_a[k] = o.sdata;
        in_is_load_a[k] = o.ld; in_is_store_a[k] = o.st; in_size_a[k] = o.size;
        in_unsigned_a[k] = o.uns; in_reg_dest_a[k] = o.rd; fwd_en_a[k] = o.fwd; fwd_data_a[k] = o.fdata;
    endtask

    // Issue one op on instance k and collect its writeback. lat is the number
    // of post-accept samples up to wb_valid (0 on timeout); bc counts busy samples.
    task automatic run_op(input int k, input op_t o, output wb_t w, output int lat, output int bc);
        int n;
        @(negedge clk);
        n = 0;
        while (busy_a[k] && n < 16) begin
            @(negedge clk);
            n++;
        end
        drive(k, o);
        in_valid_a[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        lat = 1;
        bc  = 0;
        while (!wb_valid_a[k] && lat < 12) begin
            if (busy_a[k]) bc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!wb_valid_a[k]) lat = 0;
        w.valid = wb_valid_a[k]; w.ir = wb_ir_a[k]; w.alu = wb_alu_a[k]; w.data = wb_load_data_a[k];
        w.is_load = wb_is_load_a[k]; w.rd = wb_reg_dest_a[k]; w.mis = wb_misalign_a[k];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, mk_st(32'd0, 2'd0, 32'd0));
            in_valid_a[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (busy_a[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy_a[k]); end
            checks++; if (wb_valid_a[k] !== 1'b0) begin errors++; $display("FAIL reset_wb_valid[%0d] got=%b exp=0", k, wb_valid_a[k]); end
            checks++; if (wb_misalign_a[k] !== 1'b0) begin errors++; $display("FAIL reset_misalign[%0d] got=%b exp=0", k, wb_misalign_a[k]); end
            checks++; if (wb_is_load_a[k] !== 1'b0) begin errors++; $display("FAIL reset_is_load[%0d] got=%b exp=0", k, wb_is_load_a[k]); end
            checks++; if (wb_reg_dest_a[k] !== 1'b0) begin errors++; $display("FAIL reset_reg_dest[%0d] got=%b exp=0", k, wb_reg_dest_a[k]); end
            checks++; if (wb_ir_a[k] !== 32'd0) begin errors++; $display("FAIL reset_ir[%0d] got=%h exp=0", k, wb_ir_a[k]); end
            checks++; if (wb_alu_a[k] !== 32'd0) begin errors++; $display("FAIL reset_alu[%0d] got=%h exp=0", k, wb_alu_a[k]); end
            checks++; if (wb_load_data_a[k] !== 32'd0) begin errors++; $display("FAIL reset_load_data[%0d] got=%h exp=0", k, wb_load_data_a[k]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_lb_sign();
        wb_t w; int lat; int bc; op_t o;
        run_op(0, mk_st(32'h10, 2'd2, 32'hDEADBEEF), w, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency got=%0d exp=1", lat); end
        checks++; if (w.is_load !== 1'b0) begin errors++; $display("FAIL sw_is_load got=%b exp=0", w.is_load); end
        o = mk_ld(32'h13, 2'd0, 1'b0);
        run_op(0, o, w, lat, bc);
        checks++; if (w.data !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_signed got=%h exp=ffffffde", w.data); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL lb_latency got=%0d exp=1", lat); end
        checks++; if (w.alu !== 32'h13) begin errors++; $display("FAIL lb_alu got=%h exp=00000013", w.alu); end
        checks++; if (w.ir !== o.ir) begin errors++; $display("FAIL lb_ir got=%h exp=%h", w.ir, o.ir); end
        checks++; if (w.is_load !== 1'b1 || w.rd !== 1'b1) begin errors++; $display("FAIL lb_flags got=%b%b exp=11", w.is_load, w.rd); end
        run_op(0, mk_ld(32'h13, 2'd0, 1'b1), w, lat, bc);
        checks++; if (w.data !== 32'h000000DE) begin errors++; $display("FAIL lbu got=%h exp=000000de", w.data); end
    endtask

    task automatic test_sb_merge();
        wb_t w; int lat; int bc;
        run_op(0, mk_st(32'h20, 2'd2, 32'h0), w, lat, bc);
        run_op(0, mk_st(32'h21, 2'd0, 32'hAAAAAA7F), w, lat, bc);
        run_op(0, mk_ld(32'h20, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h00007F00) begin errors++; $display("FAIL sb_merge_lw got=%h exp=00007f00", w.data); end
        run_op(0, mk_ld(32'h20, 2'd1, 1'b1), w, lat, bc);
        checks++; if (w.data !== 32'h00007F00) begin errors++; $display("FAIL sb_merge_lhu got=%h exp=00007f00", w.data); end
        run_op(0, mk_ld(32'h22, 2'd1, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h00000000) begin errors++; $display("FAIL sb_merge_lh_hi got=%h exp=00000000", w.data); end
    endtask

    task automatic test_fwd();
        wb_t w; int lat; int bc; op_t o;
        o = mk_st(32'h30, 2'd2, 32'h0);
        o.fwd = 1'b1; o.fdata = 32'h12345678;
        run_op(0, o, w, lat, bc);
        run_op(0, mk_ld(32'h30, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h12345678) begin errors++; $display("FAIL fwd_on got=%h exp=12345678", w.data); end
        o = mk_st(32'h34, 2'd2, 32'h0BADF00D);
        o.fwd = 1'b0; o.fdata = 32'hFFFFFFFF;
        run_op(0, o, w, lat, bc);
        run_op(0, mk_ld(32'h34, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h0BADF00D) begin errors++; $display("FAIL fwd_off got=%h exp=0badf00d", w.data); end
    endtask

    task automatic test_misalign();
        wb_t w; int lat; int bc;
        run_op(0, mk_ld(32'h11, 2'd1, 1'b0), w, lat, bc);
        checks++; if (w.mis !== 1'b1) begin errors++; $display("FAIL lh_mis_flag got=%b exp=1", w.mis); end
        checks++; if (w.data !== 32'd0) begin errors++; $display("FAIL lh_mis_data got=%h exp=0", w.data); end
        checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL lh_mis_timing got=%0d/%0d exp=1/0", lat, bc); end
        run_op(0, mk_ld(32'h10, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'hDEADBEEF || w.mis !== 1'b0) begin errors++; $display("FAIL mis_mem_intact got=%h exp=deadbeef", w.data); end
        run_op(0, mk_st(32'h00, 2'd2, 32'h11223344), w, lat, bc);
        run_op(0, mk_st(32'h02, 2'd2, 32'h55555555), w, lat, bc);
        checks++; if (w.mis !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sw_mis got=%b/%0d exp=1/1", w.mis, lat); end
        run_op(0, mk_ld(32'h00, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h11223344) begin errors++; $display("FAIL sw_mis_nowrite got=%h exp=11223344", w.data); end
        run_op(0, mk_ld(32'h08, 2'd3, 1'b0), w, lat, bc);
        checks++; if (w.mis !== 1'b1 || w.data !== 32'd0) begin errors++; $display("FAIL dword_on_32 got=%b/%h exp=1/0", w.mis, w.data); end
        run_op(1, mk_ld(32'h42, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.mis !== 1'b1 || lat !== 1 || bc !== 0) begin errors++; $display("FAIL mis_lat3 got=%b/%0d/%0d exp=1/1/0", w.mis, lat, bc); end
    endtask

    task automatic test_latency();
        wb_t w; int lat; int bc;
        for (int k = 1; k < 3; k++) begin
            run_op(k, mk_st(32'h40, 2'd2, 32'hCAFEBABE), w, lat, bc);
            checks++; if (lat !== 1 || bc !== 0) begin errors++; $display("FAIL st_no_busy[%0d] got=%0d/%0d exp=1/0", k, lat, bc); end
            run_op(k, mk_ld(32'h40, 2'd2, 1'b0), w, lat, bc);
            checks++; if (lat !== lat_of(k)) begin errors++; $display("FAIL ld_latency[%0d] got=%0d exp=%0d", k, lat, lat_of(k)); end
            checks++; if (bc !== lat_of(k) - 1) begin errors++; $display("FAIL ld_busy[%0d] got=%0d exp=%0d", k, bc, lat_of(k) - 1); end
            checks++; if (w.data !== 32'hCAFEBABE) begin errors++; $display("FAIL ld_data[%0d] got=%h exp=cafebabe", k, w.data); end
        end
    endtask

    task automatic test_back_to_back();
        wb_t w; int lat; int bc; int l;
        for (int k = 1; k < 3; k++) begin
            l = lat_of(k);
            run_op(k, mk_st(32'h40, 2'd2, 32'h01020304 + k), w, lat, bc);
            run_op(k, mk_st(32'h44, 2'd2, 32'hA0B0C0D0), w, lat, bc);
            @(negedge clk);
            drive(k, mk_ld(32'h40, 2'd2, 1'b0));
            in_valid_a[k] = 1'b1;
            @(posedge clk); #1;
            in_valid_a[k] = 1'b0;
            for (int c = 1; c < l; c++) begin
                checks++; if (busy_a[k] !== 1'b1 || wb_valid_a[k] !== 1'b0) begin errors++; $display("FAIL b2b_wait[%0d] c=%0d got=%b%b exp=10", k, c, busy_a[k], wb_valid_a[k]); end
                @(posedge clk); #1;
            end
            checks++; if (wb_valid_a[k] !== 1'b1 || busy_a[k] !== 1'b0) begin errors++; $display("FAIL b2b_done[%0d] got=%b%b exp=10", k, wb_valid_a[k], busy_a[k]); end
            checks++; if (wb_load_data_a[k] !== 32'h01020304 + k) begin errors++; $display("FAIL b2b_data_a[%0d] got=%h exp=%h", k, wb_load_data_a[k], 32'h01020304 + k); end
            drive(k, mk_ld(32'h44, 2'd2, 1'b1));
            in_valid_a[k] = 1'b1;
            @(posedge clk); #1;
            in_valid_a[k] = 1'b0;
            checks++; if (wb_valid_a[k] !== 1'b0 || busy_a[k] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept[%0d] got=%b%b exp=01", k, wb_valid_a[k], busy_a[k]); end
            for (int c = 2; c <= l; c++) begin
                @(posedge clk); #1;
            end
            checks++; if (wb_valid_a[k] !== 1'b1 || wb_alu_a[k] !== 32'h44) begin errors++; $display("FAIL b2b_second_done[%0d] got=%b/%h exp=1/00000044", k, wb_valid_a[k], wb_alu_a[k]); end
            checks++; if (wb_load_data_a[k] !== 32'hA0B0C0D0) begin errors++; $display("FAIL b2b_data_b[%0d] got=%h exp=a0b0c0d0", k, wb_load_data_a[k]); end
        end
        @(negedge clk);
        drive(0, mk_st(32'h50, 2'd2, 32'h6789ABCD));
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_valid_a[0] !== 1'b1 || wb_is_load_a[0] !== 1'b0) begin errors++; $display("FAIL adj_store got=%b%b exp=10", wb_valid_a[0], wb_is_load_a[0]); end
        drive(0, mk_ld(32'h50, 2'd2, 1'b0));
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        checks++; if (wb_valid_a[0] !== 1'b1 || wb_load_data_a[0] !== 32'h6789ABCD) begin errors++; $display("FAIL adj_load got=%b/%h exp=1/6789abcd", wb_valid_a[0], wb_load_data_a[0]); end
        @(posedge clk); #1;
        checks++; if (wb_valid_a[0] !== 1'b0 || wb_load_data_a[0] !== 32'h6789ABCD) begin errors++; $display("FAIL adj_hold got=%b/%h exp=0/6789abcd", wb_valid_a[0], wb_load_data_a[0]); end
    endtask

    task automatic test_reset_mid_load();
        wb_t w; int lat; int bc; logic seen;
        run_op(2, mk_st(32'h80, 2'd2, 32'h5A5AC3C3), w, lat, bc);
        @(negedge clk);
        drive(2, mk_ld(32'h80, 2'd2, 1'b0));
        in_valid_a[2] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, mk_st(32'h30, 2'd2, 32'hFFFFFFFF));
        in_valid_a[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid_a[0] = 1'b0;
        checks++; if (busy_a[2] !== 1'b0 || wb_valid_a[2] !== 1'b0) begin errors++; $display("FAIL abort_state got=%b%b exp=00", busy_a[2], wb_valid_a[2]); end
        checks++; if (wb_valid_a[0] !== 1'b0) begin errors++; $display("FAIL reset_edge_op got=%b exp=0", wb_valid_a[0]); end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wb_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_wb got=%b exp=0", seen); end
        run_op(2, mk_ld(32'h80, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h5A5AC3C3 || lat !== 4) begin errors++; $display("FAIL after_abort got=%h/%0d exp=5a5ac3c3/4", w.data, lat); end
        run_op(0, mk_ld(32'h30, 2'd2, 1'b0), w, lat, bc);
        checks++; if (w.data !== 32'h12345678) begin errors++; $display("FAIL reset_no_write got=%h exp=12345678", w.data); end
    endtask

    task automatic test_random(input int k);
        wb_t w; int lat; int bc; op_t o; int r;
        logic eld; logic emis; int elat; logic [31:0] exp_data;
        for (int a = 0; a < 256; a += 4) begin
            o = mk_st(a, 2'd2, $urandom());
            run_op(k, o, w, lat, bc);
            model_store(k, o.addr, o.size, o.sdata);
        end
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            o.ir = $urandom(); o.sdata = $urandom(); o.fdata = $urandom();
            o.ld = (r <= 3) || (r == 7);
            o.st = (r >= 4) && (r <= 7);
            o.size = 2'($urandom_range(0, 3));
            o.uns = 1'($urandom_range(0, 1));
            o.rd = 1'($urandom_range(0, 1));
            o.fwd = 1'($urandom_range(0, 1));
            o.addr = 32'($urandom_range(0, 255)) | ($urandom() & 32'hFFFFE000);
            if ($urandom_range(0, 1) == 1) o.addr = o.addr & ~(32'((1 << o.size) - 1));
            eld = o.ld && !o.st;
            emis = (o.ld || o.st) && is_mis(o.size, o.addr);
            elat = (eld && !emis) ? lat_of(k) : 1;
            exp_data = (eld && !emis) ? model_load(k, o.addr, o.size, o.uns) : 32'd0;
            run_op(k, o, w, lat, bc);
            if (o.st && !emis) model_store(k, o.addr, o.size, o.fwd ? o.fdata : o.sdata);
            checks++; if (lat !== elat || bc !== elat - 1) begin errors++; $display("FAIL rnd_timing[%0d] n=%0d got=%0d/%0d exp=%0d/%0d", k, n, lat, bc, elat, elat - 1); end
            checks++; if (w.mis !== emis || w.is_load !== eld) begin errors++; $display("FAIL rnd_flags[%0d] n=%0d got=%b%b exp=%b%b", k, n, w.mis, w.is_load, emis, eld); end
            checks++; if (w.alu !== o.addr || w.ir !== o.ir || w.rd !== o.rd) begin errors++; $display("FAIL rnd_tags[%0d] n=%0d got=%h/%h/%b exp=%h/%h/%b", k, n, w.alu, w.ir, w.rd, o.addr, o.ir, o.rd); end
            if (eld || emis) begin
                checks++; if (w.data !== exp_data) begin errors++; $display("FAIL rnd_data[%0d] n=%0d addr=%h size=%0d got=%h exp=%h", k, n, o.addr, o.size, w.data, exp_data); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_sign();
        test_sb_merge();
        test_fwd();
        test_misalign();
        test_latency();
        test_back_to_back();
        test_reset_mid_load();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2048: number of XLEN-bit words in the internal data memory; must be a power of two.
REQ-003 SHALL have parameter LAT, default 1: load access latency in cycles; legal range 1..4.
REQ-004 SHALL have ports: clk in 1 (clock); reset in 1 (synchronous, active-high).
REQ-005 SHALL have ports: in_valid in 1, in_ir in 32, in_addr in XLEN, in_store_data in XLEN.
REQ-006 SHALL have ports: in_is_load in 1, in_is_store in 1, in_size in 2 (00 byte, 01 half, 10 word, 11 dword if XLEN=64), in_unsigned in 1, in_reg_dest in 1.
REQ-007 SHALL have ports: fwd_en in 1 (substitute fwd_data for store data), fwd_data in XLEN.
REQ-008 SHALL have ports: busy out 1 (upstream stall), wb_valid out 1, wb_ir out 32, wb_alu out XLEN, wb_load_data out XLEN, wb_is_load out 1, wb_reg_dest out 1, wb_misalign out 1.

Function
REQ-009 SHALL accept an op on a rising edge where in_valid=1 and busy=0; inputs are ignored otherwise.
REQ-010 SHALL use word index in_addr[log2(DEPTH)+B-1:B], with B=log2(XLEN/8); upper address bits are ignored (wrap-around).
REQ-011 SHALL use effective store data = fwd_data when fwd_en=1, else in_store_data.
REQ-012 SHALL commit an accepted aligned store at the accept edge, writing only the addressed byte lanes from the low bytes of the effective store data.
REQ-013 SHALL complete non-memory ops and stores with wb_valid=1 one cycle after accept, with no busy assertion.
REQ-014 SHALL implement the load FSM IDLE -> WAIT(count LAT-1) -> IDLE; with LAT=1 the WAIT state is skipped.
REQ-015 SHALL hold busy=1 while in WAIT.
REQ-016 SHALL assert wb_valid for one cycle exactly LAT cycles after load accept.
REQ-017 SHALL read load data from the memory as of the accept edge, so any store accepted earlier is visible to the load.
REQ-018 SHALL extract the addressed byte/half/word lane for loads, sign-extending when in_unsigned=0 and zero-extending when in_unsigned=1.
REQ-019 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=0, or dword with addr[2:0]!=0; in_size=11 when XLEN=32 is also misaligned.
REQ-020 SHALL, for a misaligned op, perform no memory write, assert no busy, and deliver wb_valid=1 with wb_misalign=1 and wb_load_data=0 one cycle later.
REQ-021 SHALL treat in_is_load=1 with in_is_store=1 as a store only.
REQ-022 SHALL register wb_ir, wb_alu (=in_addr), wb_is_load, and wb_reg_dest alongside wb_valid.
REQ-023 SHALL hold wb_* values between valid pulses; wb_valid alone qualifies them.
REQ-024 SHALL not accept an op on the edge at which a load completes unless busy=0 in that cycle; with LAT>1, busy drops in the final load cycle to permit back-to-back issue.

Reset
REQ-025 SHALL, on reset, return the FSM to IDLE and clear busy, wb_valid, wb_misalign, wb_is_load, and wb_reg_dest to 0, and wb_ir, wb_alu, and wb_load_data to 0.
REQ-026 SHALL, on reset mid-load, abort the load so that no wb_valid is produced.
REQ-027 SHALL, on reset, not clear memory contents, and no write occurs on the reset edge.

Verification
REQ-028 Store word 0xDEADBEEF @0x10, then LB signed @0x13 (LAT=1) -> wb_load_data=0xFFFFFFDE one cycle after load accept.
REQ-029 SB 0x7F @0x21 over word 0x00000000, then LW @0x20 -> 0x00007F00; LHU @0x20 -> 0x00007F00.
REQ-030 LAT=3, LW @0x40 -> busy=1 for 2 cycles, wb_valid on cycle 3, next load accepted the same cycle busy falls.
REQ-031 SW with fwd_en=1, fwd_data=0x12345678, in_store_data=0 -> subsequent LW returns 0x12345678.
REQ-032 LH @0x11 -> wb_misalign=1, wb_load_data=0, memory unchanged; SW @0x02 -> no write.
REQ-033 Reset asserted in cycle 2 of LAT=4 load -> busy=0 and wb_valid=0 afterwards; previously stored data still readable.
